// File: rtl/clock_div_stretch_mux.sv
// Programmable 50% clock divider with per-channel glitch-free inversion by half-period stretching.
// Outputs are registered one clk after the state update; config uses valid/ready and holds one value pending until the next rising event.
module clock_div_stretch_mux #(
  parameter int DIV_WIDTH  = 8,
  parameter int CHANNELS   = 2,
  parameter int RESET_HALF = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 cfg_valid,
  input  logic [DIV_WIDTH-1:0] cfg_half,
  output logic                 cfg_ready,
  input  logic [CHANNELS-1:0]  sel,
  output logic [CHANNELS-1:0]  clock_out,
  output logic [CHANNELS-1:0]  busy,
  output logic                 period_start
);

  localparam logic [DIV_WIDTH-1:0] ONE    = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] RST_HP = (RESET_HALF == 0) ? ONE : DIV_WIDTH'(RESET_HALF);

  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [DIV_WIDTH-1:0] hp, hp_n;
  logic [DIV_WIDTH-1:0] pend_hp, pend_hp_n;
  logic                 pend, pend_n;
  logic                 base, base_n;
  logic [CHANNELS-1:0]  inv_eff, inv_n;
  logic                 toggle;
  logic                 rise;

  always_comb begin
    cnt_n     = cnt;
    base_n    = base;
    hp_n      = hp;
    pend_n    = pend;
    pend_hp_n = pend_hp;
    inv_n     = inv_eff;
    rise      = 1'b0;
    toggle    = enable && (cnt == (hp - ONE));

    if (!enable) begin
      // Frozen divider: base parked low, inversion and config apply immediately.
      cnt_n  = '0;
      base_n = 1'b0;
      inv_n  = sel;
      if (pend) begin
        hp_n   = pend_hp;
        pend_n = 1'b0;
      end
    end else if (toggle) begin
      cnt_n  = '0;
      base_n = ~base;
      // Flipping inversion together with base holds the output level for one more half-period.
      inv_n  = sel;
      rise   = ~base;
      if (rise && pend) begin
        hp_n   = pend_hp;
        pend_n = 1'b0;
      end
    end else begin
      cnt_n = cnt + ONE;
    end

    if (cfg_valid && cfg_ready) begin
      pend_hp_n = (cfg_half == '0) ? ONE : cfg_half;
      pend_n    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      base         <= 1'b0;
      hp           <= RST_HP;
      pend_hp      <= RST_HP;
      pend         <= 1'b0;
      inv_eff      <= '0;
      clock_out    <= '0;
      busy         <= '0;
      cfg_ready    <= 1'b1;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_n;
      base         <= base_n;
      hp           <= hp_n;
      pend_hp      <= pend_hp_n;
      pend         <= pend_n;
      inv_eff      <= inv_n;
      clock_out    <= {CHANNELS{base_n}} ^ inv_n;
      busy         <= sel ^ inv_n;
      cfg_ready    <= ~pend_n;
      period_start <= rise;
    end
  end

endmodule

// File: tb/tb_clock_div_stretch_mux.sv
// Scenario and randomized checks of clock_div_stretch_mux against a half-period reference model.
module tb_clock_div_stretch_mux;
  localparam int W  = 8;
  localparam int CH = 2;
  localparam int RH = 1;

  logic          clk = 1'b0;
  logic          reset, enable, cfg_valid, cfg_ready, period_start;
  logic [W-1:0]  cfg_half;
  logic [CH-1:0] sel, clock_out, busy;

  int tests = 0;
  int fails = 0;

  clock_div_stretch_mux #(.DIV_WIDTH(W), .CHANNELS(CH), .RESET_HALF(RH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_half(cfg_half), .cfg_ready(cfg_ready), .sel(sel),
    .clock_out(clock_out), .busy(busy), .period_start(period_start)
  );

  always #5 clk = ~clk;

  // Reference model: elapsed cycles in the current half-period, level of the base clock.
  int          m_elapsed, m_half, m_next_half;
  bit          m_pending, m_high;
  bit [CH-1:0] m_inv;
  bit [CH-1:0] e_clk, e_busy;
  bit          e_ready, e_ps;

  task automatic model_reset();
    m_elapsed = 0; m_half = (RH == 0) ? 1 : RH; m_next_half = m_half;
    m_pending = 0; m_high = 0; m_inv = '0;
    e_clk = '0; e_busy = '0; e_ready = 1; e_ps = 0;
  endtask

  task automatic model_step();
    bit take, rising;
    take = cfg_valid && e_ready;
    rising = 0;
    if (!enable) begin
      m_elapsed = 0; m_high = 0; m_inv = sel;
      if (m_pending) begin m_half = m_next_half; m_pending = 0; end
    end else begin
      m_elapsed++;
      if (m_elapsed == m_half) begin
        m_elapsed = 0; m_high = !m_high; m_inv = sel; rising = m_high;
        if (rising && m_pending) begin m_half = m_next_half; m_pending = 0; end
      end
    end
    if (take) begin m_next_half = (cfg_half == 0) ? 1 : int'(cfg_half); m_pending = 1; end
    e_clk = {CH{m_high}} ^ m_inv; e_busy = sel ^ m_inv; e_ready = !m_pending; e_ps = rising;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_level(input int ch, input bit lvl);
    int k;
    for (k = 0; k < 60 && clock_out[ch] !== lvl; k++) cycle();
    if (k == 60) begin
      tests++; fails++;
      $display("FAIL wait_level ch%0d: got %b want %b within 60 cycles", ch, clock_out[ch], lvl);
    end
  endtask

  task automatic set_hp(input int v);
    int k;
    for (k = 0; k < 60 && cfg_ready !== 1'b1; k++) cycle();
    cfg_valid = 1; cfg_half = W'(v);
    cycle();
    cfg_valid = 0;
    for (k = 0; k < 60 && cfg_ready !== 1'b1; k++) cycle();
    if (k == 60) begin
      tests++; fails++;
      $display("FAIL set_hp: cfg_ready got %b want 1 within 60 cycles", cfg_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1; enable = 0; cfg_valid = 0; cfg_half = '0; sel = '0;
    model_reset();
    #12;
    tests++;
    if ({clock_out, busy, cfg_ready, period_start} !== {2'b00, 2'b00, 1'b1, 1'b0}) begin
      fails++; $display("FAIL reset_values: got %b want %b", {clock_out, busy, cfg_ready, period_start}, 6'b000010);
    end
    @(negedge clk); reset = 0;
  endtask

  task automatic test_div2();
    logic prev; int ps_cnt;
    enable = 1; prev = clock_out[0]; ps_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      tests++;
      if ({clock_out, busy, cfg_ready, period_start} !== {e_clk, e_busy, e_ready, e_ps}) begin
        fails++; $display("FAIL div2_model: got %b want %b", {clock_out, busy, cfg_ready, period_start}, {e_clk, e_busy, e_ready, e_ps});
      end
      tests++;
      if (clock_out[0] !== ~prev) begin
        fails++; $display("FAIL div2_toggle: got %b want %b", clock_out[0], ~prev);
      end
      prev = clock_out[0];
      if (period_start === 1'b1) ps_cnt++;
    end
    tests++;
    if (ps_cnt != 4) begin fails++; $display("FAIL div2_period_start: got %0d pulses want 4", ps_cnt); end
  endtask

  task automatic test_config();
    int n_hi, n_lo, k;
    cfg_valid = 1; cfg_half = 8'd3;
    cycle();
    cfg_valid = 0;
    tests++;
    if (cfg_ready !== 1'b0) begin fails++; $display("FAIL cfg_ready_drop: got %b want 0", cfg_ready); end
    for (k = 0; k < 20 && cfg_ready !== 1'b1; k++) begin
      cycle();
      tests++;
      if ({clock_out, busy, cfg_ready, period_start} !== {e_clk, e_busy, e_ready, e_ps}) begin
        fails++; $display("FAIL cfg_model: got %b want %b", {clock_out, busy, cfg_ready, period_start}, {e_clk, e_busy, e_ready, e_ps});
      end
    end
    tests++;
    if (cfg_ready !== 1'b1) begin fails++; $display("FAIL cfg_ready_return: got %b want 1", cfg_ready); end
    wait_level(0, 0); wait_level(0, 1);
    n_hi = 1;
    for (k = 0; k < 20; k++) begin cycle(); if (clock_out[0] === 1'b1) n_hi++; else break; end
    n_lo = 1;
    for (k = 0; k < 20; k++) begin cycle(); if (clock_out[0] === 1'b0) n_lo++; else break; end
    tests++;
    if (n_hi != 3 || n_lo != 3) begin fails++; $display("FAIL cfg_hp3_phases: got hi=%0d lo=%0d want 3/3", n_hi, n_lo); end
  endtask

  task automatic test_stretch();
    int n; bit busy_seen;
    set_hp(2);
    wait_level(0, 0); wait_level(0, 1);
    sel[0] = 1'b1;
    n = 1; busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      tests++;
      if ({clock_out, busy, cfg_ready, period_start} !== {e_clk, e_busy, e_ready, e_ps}) begin
        fails++; $display("FAIL stretch_model: got %b want %b", {clock_out, busy, cfg_ready, period_start}, {e_clk, e_busy, e_ready, e_ps});
      end
      if (busy[0] === 1'b1) busy_seen = 1;
      if (clock_out[0] === 1'b1) n++; else break;
    end
    tests++;
    if (n != 4) begin fails++; $display("FAIL stretch_width: got %0d want 4", n); end
    tests++;
    if (!busy_seen || busy[0] !== 1'b0) begin fails++; $display("FAIL stretch_busy: seen=%0d now=%b want 1/0", busy_seen, busy[0]); end
    tests++;
    if (clock_out[1] !== ~clock_out[0]) begin fails++; $display("FAIL stretch_inverted: got %b want ch0 opposite ch1", clock_out); end
  endtask

  task automatic test_cancel();
    int n;
    set_hp(4);
    wait_level(1, 0); wait_level(1, 1);
    n = 1;
    sel[1] = 1'b1;
    cycle(); if (clock_out[1] === 1'b1) n++;
    tests++;
    if (busy[1] !== 1'b1) begin fails++; $display("FAIL cancel_busy_set: got %b want 1", busy[1]); end
    cycle(); if (clock_out[1] === 1'b1) n++;
    sel[1] = 1'b0;
    cycle(); if (clock_out[1] === 1'b1) n++;
    tests++;
    if (busy[1] !== 1'b0) begin fails++; $display("FAIL cancel_busy_clear: got %b want 0", busy[1]); end
    for (int k = 0; k < 20; k++) begin
      cycle();
      tests++;
      if ({clock_out, busy, cfg_ready, period_start} !== {e_clk, e_busy, e_ready, e_ps}) begin
        fails++; $display("FAIL cancel_model: got %b want %b", {clock_out, busy, cfg_ready, period_start}, {e_clk, e_busy, e_ready, e_ps});
      end
      if (clock_out[1] === 1'b1) n++; else break;
    end
    tests++;
    if (n != 4) begin fails++; $display("FAIL cancel_no_stretch: got %0d want 4", n); end
  endtask

  task automatic test_zero_cfg();
    logic prev;
    set_hp(0);
    prev = clock_out[1];
    for (int k = 0; k < 6; k++) begin
      cycle();
      tests++;
      if (clock_out[1] !== ~prev || {clock_out, busy, cfg_ready, period_start} !== {e_clk, e_busy, e_ready, e_ps}) begin
        fails++; $display("FAIL zero_cfg_hp1: got %b want %b (ch1 toggling)", {clock_out, busy, cfg_ready, period_start}, {e_clk, e_busy, e_ready, e_ps});
      end
      prev = clock_out[1];
    end
  endtask

  task automatic test_async_reset();
    set_hp(6);
    sel[1] = ~sel[1];
    cfg_valid = 1; cfg_half = 8'd5;
    cycle();
    cfg_valid = 0;
    tests++;
    if ({clock_out, busy, cfg_ready, period_start} !== {e_clk, e_busy, e_ready, e_ps}) begin
      fails++; $display("FAIL pre_reset_model: got %b want %b", {clock_out, busy, cfg_ready, period_start}, {e_clk, e_busy, e_ready, e_ps});
    end
    #2 reset = 1;
    #1;
    tests++;
    if ({clock_out, busy, cfg_ready, period_start} !== {2'b00, 2'b00, 1'b1, 1'b0}) begin
      fails++; $display("FAIL async_reset: got %b want %b", {clock_out, busy, cfg_ready, period_start}, 6'b000010);
    end
    model_reset();
    @(negedge clk); reset = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      tests++;
      if ({clock_out, busy, cfg_ready, period_start} !== {e_clk, e_busy, e_ready, e_ps}) begin
        fails++; $display("FAIL post_reset_model: got %b want %b", {clock_out, busy, cfg_ready, period_start}, {e_clk, e_busy, e_ready, e_ps});
      end
    end
  endtask

  task automatic test_disabled();
    int n, run0, run1, min0, min1;
    logic [CH-1:0] prev;
    enable = 0; sel = 2'b11;
    cfg_valid = 1; cfg_half = 8'd3;
    cycle();
    cfg_valid = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      tests++;
      if (clock_out !== 2'b11 || {clock_out, busy, cfg_ready, period_start} !== {e_clk, e_busy, e_ready, e_ps}) begin
        fails++; $display("FAIL disabled_static: got %b want %b", {clock_out, busy, cfg_ready, period_start}, {2'b11, e_busy, e_ready, e_ps});
      end
    end
    enable = 1;
    n = 0;
    for (int k = 0; k < 20; k++) begin cycle(); n++; if (clock_out !== 2'b11) break; end
    tests++;
    if (n != 3) begin fails++; $display("FAIL enable_first_edge: got %0d cycles want 3", n); end
    prev = clock_out; run0 = 1; run1 = 1; min0 = 1000; min1 = 1000;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (clock_out[0] === prev[0]) run0++; else begin if (run0 < min0) min0 = run0; run0 = 1; end
      if (clock_out[1] === prev[1]) run1++; else begin if (run1 < min1) min1 = run1; run1 = 1; end
      prev = clock_out;
    end
    tests++;
    if (min0 < 3 || min1 < 3) begin fails++; $display("FAIL min_pulse_width: got %0d/%0d want >=3", min0, min1); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      enable = ($urandom_range(0, 39) != 0);
      for (int c = 0; c < CH; c++) if ($urandom_range(0, 7) == 0) sel[c] = ~sel[c];
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_half = W'($urandom_range(0, 5));
      cycle();
      tests++;
      if ({clock_out, busy, cfg_ready, period_start} !== {e_clk, e_busy, e_ready, e_ps}) begin
        fails++; $display("FAIL random_model cyc%0d: got %b want %b", k, {clock_out, busy, cfg_ready, period_start}, {e_clk, e_busy, e_ready, e_ps});
      end
    end
    cfg_valid = 0;
  endtask

  initial begin
    test_reset();
    test_div2();
    test_config();
    test_stretch();
    test_cancel();
    test_zero_cfg();
    test_async_reset();
    test_disabled();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clock_div_stretch_mux.md
CLOCK_DIV_STRETCH_MUX -- requirements
Module: clock_div_stretch_mux

Interface
REQ-001 Parameter DIV_WIDTH, default 8: width of the half-period count.
REQ-002 Parameter CHANNELS, default 2: number of independent output clock channels.
REQ-003 Parameter RESET_HALF, default 1: half-period (in clk cycles) loaded at reset; a value of 0 is treated as 1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, asynchronous and active-high.
REQ-006 enable  input  1  1 = divider runs; 0 = divider frozen.
REQ-007 cfg_valid  input  1  new half-period offered.
REQ-008 cfg_half  input  DIV_WIDTH  offered half-period in clk cycles; 0 is treated as 1.
REQ-009 cfg_ready  output  1  config slot free; transfer occurs when cfg_valid and cfg_ready are both 1.
REQ-010 sel  input  CHANNELS  per-channel requested inversion: 0 = normal, 1 = inverted.
REQ-011 clock_out  output  CHANNELS  per-channel generated clock, driven directly from a register.
REQ-012 busy  output  CHANNELS  per-channel inversion change pending.
REQ-013 period_start  output  1  one-cycle pulse when the base clock rises.

Function
REQ-014 Internal state: cnt (DIV_WIDTH), base (1), hp (active half-period), pend_hp plus pend flag, and inv_eff (CHANNELS).
REQ-015 Enabled cycle where cnt == hp-1 is a "toggle event": base <= ~base and cnt <= 0; any other enabled cycle: cnt <= cnt+1.
REQ-016 Divider period = 2*hp clk cycles; duty = 50 %.
REQ-017 A rising event (base 0->1) asserts period_start for exactly the following cycle.
REQ-018 Config transfer: pend_hp <= cfg_half (0 mapped to 1), pend <= 1, cfg_ready <= 0.
REQ-019 While pend == 1, cfg_ready is 0 and cfg_valid is ignored.
REQ-020 Pending config loads hp at the next rising event; that event has cnt <= 0; cfg_ready returns to 1 on the following cycle.
REQ-021 Channel i: clock_out[i] = base ^ inv_eff[i], registered from next-state values so no combinational glitch reaches the output.
REQ-022 busy[i] = (sel[i] != inv_eff[i]), registered.
REQ-023 While busy[i] = 1, at the next toggle event inv_eff[i] flips together with base.
REQ-024 Result of REQ-023: clock_out[i] holds its level for one extra half-period (stretch); it never produces a pulse shorter than hp cycles.
REQ-025 If sel[i] returns to inv_eff[i] before the toggle event, the change is cancelled: no stretch, and busy[i] clears.
REQ-026 Channels are independent; several channels may stretch on the same event.
REQ-027 enable = 0 holds cnt at 0 and base at 0; no events or period_start pulses occur.
REQ-028 While enable = 0, sel changes apply to inv_eff on the next cycle (single static edge); a pending config loads hp on the next cycle.
REQ-029 enable 0->1 resumes with cnt = 0 and base = 0; the first event occurs hp cycles later.
REQ-030 enable dropping mid half-period forces base to 0 on the next cycle; a resulting short high phase is permitted only at disable.

Reset
REQ-031 Reset gives cnt = 0, base = 0, hp = RESET_HALF (0 mapped to 1), pend = 0, inv_eff = 0.
REQ-032 Reset gives clock_out = 0, busy = 0, cfg_ready = 1, period_start = 0.
REQ-033 Reset asserted mid-operation, including mid-stretch or with a config pending, discards all pending state immediately, independent of clk.
REQ-034 First toggle event after reset release occurs hp cycles after the first enabled clk edge.

Verification
REQ-035 Reset, RESET_HALF=1, enable=1, sel=0 -> clock_out[0] toggles every cycle (clk/2); period_start pulses every 2 cycles.
REQ-036 cfg_half=3 offered while running at hp=1 -> cfg_ready drops; hp=3 applies at the next rising event; subsequent high and low phases are 3 cycles each; cfg_ready returns to 1.
REQ-037 hp=2, sel[0] 0->1 mid high phase -> clock_out[0] high for 4 cycles, then inverted relative to base; busy[0] high until the event; clock_out[1] unaffected.
REQ-038 hp=4, sel[1] pulsed 1 for 2 cycles between events -> no stretch, inv_eff[1] stays 0, busy[1] clears.
REQ-039 cfg_half=0 -> behaves as hp=1. Reset asserted during a pending stretch -> all outputs take their REQ-032 reset values asynchronously.
REQ-040 enable=0 with sel=2'b11 -> clock_out = 2'b11 static; enable=1 -> the first edge occurs after hp cycles, and every pulse is at least hp cycles wide.
